reg_file_mp: RTL and testbench

Parametrised multi-read-port register file for the RV32IM pipeline. It sits between decode/ID (read and reserve) and writeback (write).
- Adds byte-strobed writes, a hardwired-zero entry and write-to-read bypass.
- Adds a per-register pending-write scoreboard for hazard detection.
- Adds a sequential, one-entry-per-cycle soft clear with a busy handshake.

---
 rtl/rf_pkg.sv | 30 +++
 rtl/rf_scoreboard.sv | 52 +++++
 rtl/reg_file_mp.sv | 112 +++++++++++
 tb/tb_reg_file_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types, constants and strobe-merge helper for reg_file_mp
package rf_pkg;

    typedef enum logic {
        RF_IDLE     = 1'b0,
        RF_CLEARING = 1'b1
    } rf_clr_state_t;

    localparam int RF_DATA_W  = 32;
    localparam int STRB_W     = RF_DATA_W / 8;
    localparam int MAX_DATA_W = 256;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Operates at the widest supported width; callers size in and out with casts.
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_data,
        input logic [MAX_DATA_W-1:0] new_data,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_data;
        for (int b = 0; b < MAX_STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write busy bits with read-port lookups
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_set,
    input  logic [ADDR_W-1:0]        i_set_addr,
    input  logic                     i_clr,
    input  logic [ADDR_W-1:0]        i_clr_addr,
    input  logic                     i_flush,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD-1:0]        o_busy
);

    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

    logic [DEPTH-1:0] r_busy;
    logic             w_set_ok;
    logic             w_clr_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_A;
    endfunction

    assign w_set_ok = i_set && in_range(i_set_addr) && !(ZERO_REG && i_set_addr == '0);
    assign w_clr_ok = i_clr && in_range(i_clr_addr);

    // Set is applied after clear so a same-cycle reserve keeps the register busy.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            if (w_clr_ok) r_busy[i_clr_addr] <= 1'b0;
            if (w_set_ok) r_busy[i_set_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
        logic [ADDR_W-1:0] w_ra;
        assign w_ra      = i_raddr[k*ADDR_W +: ADDR_W];
        assign o_busy[k] = in_range(w_ra) && r_busy[w_ra];
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-read-port register file with bypass, scoreboard and soft clear
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_resetn,
    input  logic                     i_write,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [DATA_W/8-1:0]      i_wstrb,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata,
    output logic [NUM_RD-1:0]        o_rbusy,
    input  logic                     i_resv,
    input  logic [ADDR_W-1:0]        i_resv_addr,
    input  logic                     i_clear,
    output logic                     o_clr_busy
);

    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH-1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    rf_clr_state_t     r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_clr_busy;

    logic              w_idle;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_wr_old;
    logic [DATA_W-1:0] w_wr_merged;
    logic [NUM_RD-1:0] w_sb_busy;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_A) && !(ZERO_REG && a == '0);
    endfunction

    assign w_idle      = (r_state == RF_IDLE);
    assign w_wr_ok     = i_write && w_idle && addr_ok(i_waddr);
    assign w_wr_old    = addr_ok(i_waddr) ? r_mem[i_waddr] : '0;
    assign w_wr_merged = DATA_W'(strb_merge(MAX_DATA_W'(w_wr_old), MAX_DATA_W'(i_wdata),
                                            MAX_STRB_W'(i_wstrb)));
    assign o_clr_busy  = r_clr_busy;

    // Reserves are dropped while clearing and on the edge that starts a clear.
    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_set      (i_resv && w_idle && !i_clear),
        .i_set_addr (i_resv_addr),
        .i_clr      (i_write && w_idle),
        .i_clr_addr (i_waddr),
        .i_flush    (w_idle && i_clear),
        .i_raddr    (i_raddr),
        .o_busy     (w_sb_busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_byp;
        assign w_ra  = i_raddr[k*ADDR_W +: ADDR_W];
        assign w_byp = BYPASS && w_wr_ok && (i_waddr == w_ra);
        assign o_rdata[k*DATA_W +: DATA_W] = w_byp ? w_wr_merged :
                                             (addr_ok(w_ra) ? r_mem[w_ra] : '0);
        assign o_rbusy[k] = w_sb_busy[k] && !w_byp;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= RF_IDLE;
            r_cnt      <= '0;
            r_clr_busy <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (w_wr_ok) r_mem[i_waddr] <= w_wr_merged;
                    if (i_clear) begin
                        r_state    <= RF_CLEARING;
                        r_cnt      <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                RF_CLEARING: begin
                    r_mem[r_cnt] <= '0;
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= RF_IDLE;
                        r_clr_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp (DEPTH 32 and DEPTH 24 instances)
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [9:0]  raddr = '0;
    logic        resv = 1'b0;
    logic [4:0]  resv_addr = '0;
    logic        clear = 1'b0;
    logic [63:0] rdata, rdata2;
    logic [1:0]  rbusy, rbusy2;
    logic        clr_busy, clr_busy2;

    always #5 clk = ~clk;

    reg_file_mp u_dut (
        .i_clk(clk), .i_resetn(resetn), .i_write(write), .i_waddr(waddr),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_raddr(raddr), .o_rdata(rdata),
        .o_rbusy(rbusy), .i_resv(resv), .i_resv_addr(resv_addr),
        .i_clear(clear), .o_clr_busy(clr_busy)
    );

    reg_file_mp #(.DEPTH(24)) u_dut24 (
        .i_clk(clk), .i_resetn(resetn), .i_write(write), .i_waddr(waddr),
        .i_wdata(wdata), .i_wstrb(wstrb), .i_raddr(raddr), .o_rdata(rdata2),
        .o_rbusy(rbusy2), .i_resv(resv), .i_resv_addr(resv_addr),
        .i_clear(clear), .o_clr_busy(clr_busy2)
    );

    // kind: 0 rdata port0, 1 rdata port1, 2 rbusy, 3 clr_busy, 4 DEPTH-24 rdata port0
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    logic [31:0] m_act;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic void expect_v(input string name, input int kind, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.kind)
                0:       m_act = rdata[31:0];
                1:       m_act = rdata[63:32];
                2:       m_act = {30'b0, rbusy};
                3:       m_act = {31'b0, clr_busy};
                default: m_act = rdata2[31:0];
            endcase
            n_tests++;
            if (m_act !== m_e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", m_e.name, m_act, m_e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        write = 1'b0;
        resv  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        write = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = s;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] e0;

        step();
        rd(5, 5);
        expect_v("reset_rd0", 0, 32'h0);
        expect_v("reset_rd1", 1, 32'h0);
        expect_v("reset_rbusy", 2, 32'h0);
        expect_v("reset_clr_busy", 3, 32'h0);
        step();
        resetn = 1'b1;
        wr(5, 32'hDEADBEEF, 4'hF);
        rd(1, 1);
        step();
        idle_in();
        rd(5, 5);
        expect_v("x5_port0", 0, 32'hDEADBEEF);
        expect_v("x5_port1", 1, 32'hDEADBEEF);
        step();
        wr(0, 32'h1234, 4'hF);
        rd(0, 5);
        expect_v("x0_no_bypass", 0, 32'h0);
        step();
        idle_in();
        expect_v("x0_reads_zero", 0, 32'h0);

        step();
        wr(3, 32'h11223344, 4'hF);
        step();
        wr(3, 32'hAABBCCDD, 4'h3);
        rd(3, 5);
        expect_v("bypass_merge", 0, 32'h1122CCDD);
        expect_v("bypass_other_port", 1, 32'hDEADBEEF);
        step();
        idle_in();
        expect_v("merge_stored", 0, 32'h1122CCDD);

        step();
        resv = 1'b1;
        resv_addr = 7;
        rd(5, 7);
        expect_v("resv_same_cycle", 2, 32'h0);
        step();
        resv = 1'b0;
        expect_v("resv_busy", 2, 32'h2);
        step();
        wr(7, 32'h77, 4'hF);
        expect_v("write_forces_not_busy", 2, 32'h0);
        expect_v("write_bypass_x7", 1, 32'h77);
        step();
        idle_in();
        expect_v("write_clears_busy", 2, 32'h0);
        step();
        wr(7, 32'h99, 4'hF);
        resv = 1'b1;
        resv_addr = 7;
        expect_v("resv_write_bypass", 2, 32'h0);
        step();
        idle_in();
        expect_v("resv_wins", 2, 32'h2);
        expect_v("resv_write_data", 1, 32'h99);
        step();
        wr(7, 32'h12345678, 4'h0);
        expect_v("strb0_bypass", 1, 32'h99);
        expect_v("strb0_rbusy", 2, 32'h0);
        step();
        idle_in();
        expect_v("strb0_clears_busy", 2, 32'h0);
        expect_v("strb0_data_kept", 1, 32'h99);

        for (int i = 0; i < 32; i++) begin
            step();
            wr(5'(i), 32'h100 + 32'(i), 4'hF);
        end
        step();
        idle_in();
        resv = 1'b1;
        resv_addr = 9;
        rd(31, 9);
        expect_v("fill_x31", 0, 32'h11F);
        step();
        resv_addr = 4;
        clear = 1'b1;
        wr(2, 32'hABC, 4'hF);
        rd(0, 9);
        expect_v("busy_before_flush", 2, 32'h2);
        expect_v("clr_busy_start_cycle", 3, 32'h0);
        for (int j = 0; j <= 32; j++) begin
            step();
            idle_in();
            rd(5'(j), 5'(j - 1));
            if (j == 0) rd(0, 9);
            expect_v("clr_busy_window", 3, (j < 32) ? 32'h1 : 32'h0);
            if (j < 32) begin
                e0 = (j == 0) ? 32'h0 : (j == 2) ? 32'hABC : 32'h100 + 32'(j);
                expect_v("clr_not_yet_cleared", 0, e0);
            end
            if (j >= 1) expect_v("clr_already_cleared", 1, 32'h0);
            if (j == 0) expect_v("clr_flushed_busy", 2, 32'h0);
            if (j == 4) expect_v("clr_resv_dropped", 2, 32'h0);
            if (j == 3) wr(20, 32'hFFFF, 4'hF);
            if (j == 5) clear = 1'b1;
        end
        for (int i = 0; i < 32; i++) begin
            step();
            rd(5'(i), 5'(i));
            expect_v("clr_done_zero", 0, 32'h0);
        end

        step();
        wr(10, 32'hA0A0, 4'hF);
        step();
        idle_in();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        step();
        rd(10, 1);
        expect_v("pre_reset_x10", 0, 32'hA0A0);
        expect_v("pre_reset_clr_busy", 3, 32'h1);
        step();
        resetn = 1'b0;
        expect_v("async_reset_rd0", 0, 32'h0);
        expect_v("async_reset_clr_busy", 3, 32'h0);
        expect_v("async_reset_rbusy", 2, 32'h0);
        step();
        resetn = 1'b1;
        wr(10, 32'h1, 4'hF);
        step();
        wr(31, 32'h31, 4'hF);
        step();
        idle_in();
        clear = 1'b1;
        expect_v("restart_idle", 3, 32'h0);
        for (int j = 0; j <= 32; j++) begin
            step();
            clear = 1'b0;
            rd(0, 0);
            expect_v("restart_clr_busy", 3, (j < 32) ? 32'h1 : 32'h0);
            if (j == 0) begin
                rd(31, 0);
                expect_v("restart_x31_kept", 0, 32'h31);
            end
            if (j == 10) begin
                rd(10, 0);
                expect_v("restart_from_zero", 0, 32'h1);
            end
            if (j == 11) begin
                rd(0, 10);
                expect_v("restart_x10_cleared", 1, 32'h0);
            end
        end

        step();
        wr(30, 32'hCAFE, 4'hF);
        rd(30, 23);
        expect_v("d24_no_bypass_30", 4, 32'h0);
        step();
        wr(23, 32'h23, 4'hF);
        rd(30, 0);
        expect_v("d24_read30", 4, 32'h0);
        step();
        idle_in();
        rd(23, 0);
        expect_v("d24_x23", 4, 32'h23);
        step();
        rd(6, 0);
        expect_v("d24_alias6", 4, 32'h0);
        step();
        rd(14, 0);
        expect_v("d24_alias14", 4, 32'h0);

        step();
        step();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
